// File: rtl/if_id_skid_reg_pkg.sv
// Shared definitions for the IF/ID skid register: occupancy states and the
// architectural NOP (addi x0,x0,0) shown while the output entry is invalid.
package if_id_skid_reg_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // EMPTY: nothing held; FULL: main entry only; SKID: main and skid entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  // Ready to fetch whenever the skid slot is free.
  function automatic logic can_accept(state_t st);
    return st != ST_SKID;
  endfunction

  // Output entry is meaningful whenever anything is held.
  function automatic logic has_entry(state_t st);
    return st != ST_EMPTY;
  endfunction

endpackage

// File: rtl/if_id_skid_reg_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q;

  // Count up on enable, stick at all-ones, clear has priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (i_clr) begin
      cnt_q <= '0;
    end else if (i_en && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a two-entry skid buffer. o_ready and o_valid
// are decoded from registered state only, so downstream back-pressure never
// reaches fetch combinationally. Flush squashes both entries and any fetch
// presented in the same cycle; i_en low freezes everything.
module if_id_skid_reg
  import if_id_skid_reg_pkg::*;
#(
  parameter int                  NB_INSTR  = 32,
  parameter int                  NB_PC     = 32,
  parameter int                  NB_CNT    = 16,
  parameter logic [NB_INSTR-1:0] NOP_INSTR = NB_INSTR'(NOP_INSTR_DEFAULT)
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_flush,
  input  logic [NB_INSTR-1:0] i_instr,
  input  logic [NB_PC-1:0]    i_pc,
  input  logic [NB_PC-1:0]    i_pc_next,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [NB_INSTR-1:0] o_instr,
  output logic [NB_PC-1:0]    o_pc,
  output logic [NB_PC-1:0]    o_pc_next,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [NB_CNT-1:0]   o_stall_cnt
);

  state_t state_q, state_d;

  logic [NB_INSTR-1:0] main_instr_q, skid_instr_q;
  logic [NB_PC-1:0]    main_pc_q,    skid_pc_q;
  logic [NB_PC-1:0]    main_pcn_q,   skid_pcn_q;

  logic push, pop;
  logic load_main_in, load_main_skid, load_skid;
  logic stall_inc;

  assign o_ready = can_accept(state_q);
  assign o_valid = has_entry(state_q);

  assign push = i_valid & o_ready & i_en;
  assign pop  = o_valid & i_ready & i_en;

  // Next occupancy and which slot loads what; flush overrides everything.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d      = ST_FULL;
            load_main_in = 1'b1;
          end
        end
        ST_FULL: begin
          if (push && pop) begin
            load_main_in = 1'b1;
          end else if (push) begin
            state_d   = ST_SKID;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (pop) begin
            state_d        = ST_FULL;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and main entry; main is cleared so o_pc/o_pc_next read 0 after reset.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q      <= ST_EMPTY;
      main_instr_q <= '0;
      main_pc_q    <= '0;
      main_pcn_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_instr_q <= i_instr;
        main_pc_q    <= i_pc;
        main_pcn_q   <= i_pc_next;
      end else if (load_main_skid) begin
        main_instr_q <= skid_instr_q;
        main_pc_q    <= skid_pc_q;
        main_pcn_q   <= skid_pcn_q;
      end
    end
  end

  // Skid entry data.
  always_ff @(posedge clk) begin
    // NOTE: the skid payload has no reset; it is only read after a load,
    // which the state register guarantees, so resetting it buys nothing.
    if (load_skid) begin
      skid_instr_q <= i_instr;
      skid_pc_q    <= i_pc;
      skid_pcn_q   <= i_pc_next;
    end
  end

  assign o_instr   = o_valid ? main_instr_q : NOP_INSTR;
  assign o_pc      = main_pc_q;
  assign o_pc_next = main_pcn_q;

  // A stall cycle: something to hand over, decode not taking it, not frozen
  // and not being squashed.
  assign stall_inc = o_valid & ~i_ready & i_en & ~i_flush;

  sat_counter #(
    .W(NB_CNT)
  ) u_stall_cnt (
    .clk  (clk),
    .i_clr(i_rst),
    .i_en (stall_inc),
    .o_cnt(o_stall_cnt)
  );

endmodule

// File: doc/if_id_skid_reg.md
# if_id_skid_reg

Parametrised IF/ID pipeline register with a valid/ready handshake, a two-entry skid buffer, synchronous flush with NOP bubble injection, a global freeze enable, and a saturating stall-cycle counter. It sits between the fetch stage and the decode stage and carries instruction, PC and PC+4. Downstream back-pressure never propagates combinationally to fetch, and a branch flush cleanly squashes all in-flight fetches.

## Interface
Parameters:
- NB_INSTR, 32, instruction width
- NB_PC, 32, PC width
- NB_CNT, 16, stall counter width
- NOP_INSTR, 32'h00000013, instruction driven whenever output is invalid (addi x0,x0,0)

Ports:
- clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_en  in  1  global enable; low freezes transfers and counter (debug halt)
- i_flush  in  1  squash all held entries
- i_instr  in  NB_INSTR  instruction from IF
- i_pc  in  NB_PC  PC from IF
- i_pc_next  in  NB_PC  PC+4 from IF
- i_valid  in  1  IF presents a valid fetch
- o_ready  out  1  block can accept a fetch this cycle
- o_instr  out  NB_INSTR  instruction to ID; NOP_INSTR when o_valid=0
- o_pc  out  NB_PC  PC to ID
- o_pc_next  out  NB_PC  PC+4 to ID
- o_valid  out  1  output entry valid
- i_ready  in  1  ID accepts this cycle (not stalled)
- o_stall_cnt  out  NB_CNT  saturating count of stall cycles

## Operation
- Storage: main entry (drives outputs) and skid entry, each {instr, pc, pc_next}; state EMPTY / FULL / SKID.
- push = i_valid & o_ready & i_en; pop = o_valid & i_ready & i_en.
- o_ready = (state != SKID); o_valid = (state != EMPTY). Both decoded from state only.
- Transitions (when i_flush=0):
  - EMPTY: push -> FULL, main<=in.
  - FULL: push&pop -> FULL, main<=in; push&!pop -> SKID, skid<=in; !push&pop -> EMPTY; neither -> hold.
  - SKID: pop -> FULL, main<=skid; else hold. No push possible.
- i_flush=1: next state EMPTY regardless of i_en, push or pop; input in the same cycle is dropped; stored data need not be cleared.
- o_instr = main.instr when o_valid, else NOP_INSTR; o_pc/o_pc_next show main contents (0 after reset).
- o_stall_cnt increments when o_valid & !i_ready & i_en & !i_flush; saturates at 2^NB_CNT-1; cleared only by i_rst.
- i_en=0: state, entries and counter hold; outputs stable.

## Timing
- Reset values: state EMPTY, o_valid=0, o_ready=1, o_instr=NOP_INSTR, o_pc=0, o_pc_next=0, o_stall_cnt=0.
- Latency: push in cycle N -> o_valid with that data in cycle N+1.
- Throughput: one instruction per cycle when i_ready held high.
- o_ready is a registered function of state; no combinational path i_ready -> o_ready, i_valid -> o_valid.
- Order preserved: skid entry always pops after main.
- Reset has priority over flush; flush over enable; mid-operation reset discards both entries next edge.

## Structure
- Shared header cpu_defs.vh: NOP_INSTR value, state encodings (EMPTY=2'd0, FULL=2'd1, SKID=2'd2).
- One sub-module: sat_counter (parametrised width, enable, sync clear) for o_stall_cnt.
- Target 150-250 lines RTL.

## Test plan
- Reset then idle: o_valid=0, o_ready=1, o_instr=32'h00000013, o_stall_cnt=0.
- Streaming: i_ready=1, push instrs 0xA0..0xA4 at PCs 0x100..0x110 on consecutive cycles -> same sequence on outputs one cycle later, no gaps.
- Back-pressure: i_ready=0 after two pushes -> state SKID, o_ready=0, o_instr holds first instr; raise i_ready -> both emerge in order; o_stall_cnt equals stalled cycles.
- Flush in SKID with simultaneous i_valid=1 -> next cycle o_valid=0, o_instr=NOP, o_ready=1, flushed input never appears.
- Freeze: i_en=0 for 5 cycles while FULL with i_ready=0 -> outputs and o_stall_cnt unchanged; with NB_CNT=4, 20 stall cycles -> o_stall_cnt=15.
- Reset asserted while SKID -> next edge reset values, subsequent push at PC 0x200 appears one cycle later.
